// File: rtl/maf_pkg.sv
// Shared encodings, limits and FSM states for the FMA normalization scheduler.
// Optional counters in maf_norm_sched are enabled with MAF_NORM_STATS_EN.
package maf_pkg;

  localparam logic [2:0] MODE_WIDE0 = 3'b000;
  localparam logic [2:0] MODE_DUAL  = 3'b001;
  localparam logic [2:0] MODE_WIDE1 = 3'b010;

  localparam int WIDE_MAX_DEF = 55;
  localparam int LANE_MAX_DEF = 27;
  localparam int MAX_FIX_DEF  = 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/maf_norm_amt.sv
// Maps mode and leading-one flags/positions to initial shift amounts.
// skip marks operations that need no shifter pass (invalid mode or all-zero).
module maf_norm_amt
  import maf_pkg::*;
(
  input  logic [2:0] cont,
  input  logic [1:0] v,
  input  logic [9:0] p,
  output logic [5:0] amt_hi,
  output logic [4:0] amt_lo,
  output logic [1:0] zero,
  output logic       skip
);

  always_comb begin
    amt_hi = '0;
    amt_lo = '0;
    zero   = 2'b11;
    skip   = 1'b1;
    unique case (1'b1)
      (cont == MODE_WIDE0) || (cont == MODE_WIDE1): begin
        amt_hi = v[1] ? {1'b0, p[9:5]} :
                 v[0] ? {1'b1, p[4:0]} : 6'd0;
        zero   = {~|v, 1'b0};
        skip   = ~|v;
      end
      cont == MODE_DUAL: begin
        amt_hi = {1'b0, p[9:5]};
        amt_lo = p[4:0];
        zero   = ~v;
        skip   = ~|v;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/maf_norm_sched.sv
// Normalization step sequencer: shift, MSB check, one-bit LZA correction.
// Define MAF_NORM_STATS_EN to add the stat_ops/stat_fix counters.
module maf_norm_sched
  import maf_pkg::*;
#(
  parameter int WIDE_MAX = WIDE_MAX_DEF,
  parameter int LANE_MAX = LANE_MAX_DEF,
  parameter int MAX_FIX  = MAX_FIX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_cont,
  input  logic [1:0] in_v,
  input  logic [9:0] in_p,
  output logic       sh_valid,
  input  logic       sh_ready,
  output logic [5:0] sh_amt_hi,
  output logic [4:0] sh_amt_lo,
  input  logic       msb_valid,
  input  logic [1:0] msb,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_amt_hi,
  output logic [4:0] out_amt_lo,
  output logic [1:0] out_zero,
  output logic       out_err
`ifdef MAF_NORM_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_fix
`endif
);

  state_t      state_q, state_d;
  logic        armed_q;
  logic [2:0]  cont_q;
  logic [5:0]  hi_q;
  logic [4:0]  lo_q;
  logic [1:0]  zero_q;
  logic        err_q;
  logic [1:0]  fix_q;
  logic [1:0]  need_q;

  logic [5:0]  dec_hi;
  logic [4:0]  dec_lo;
  logic [1:0]  dec_zero;
  logic        dec_skip;

  logic        acc;
  logic        dual;
  logic        fix_ok;
  logic [1:0]  need_d;
  logic [6:0]  hi_inc;
  logic [5:0]  lo_inc;
  logic        hi_ovf;
  logic        lo_ovf;

  maf_norm_amt u_amt (
    .cont   (in_cont),
    .v      (in_v),
    .p      (in_p),
    .amt_hi (dec_hi),
    .amt_lo (dec_lo),
    .zero   (dec_zero),
    .skip   (dec_skip)
  );

  assign acc    = in_valid && in_ready;
  assign dual   = (cont_q == MODE_DUAL);
  assign fix_ok = (fix_q < 2'(MAX_FIX));
  assign need_d = {~zero_q[1] & ~msb[1],
                   dual & ~zero_q[0] & ~msb[0]}
                  & {2{fix_ok}};
  assign hi_inc = {1'b0, hi_q} + 7'd1;
  assign lo_inc = {1'b0, lo_q} + 6'd1;
  assign hi_ovf = dual ? (hi_inc > 7'(LANE_MAX))
                       : (hi_inc > 7'(WIDE_MAX));
  assign lo_ovf = (lo_inc > 6'(LANE_MAX));

  assign sh_amt_hi  = hi_q;
  assign sh_amt_lo  = lo_q;
  assign out_amt_hi = hi_q;
  assign out_amt_lo = lo_q;
  assign out_zero   = zero_q;
  assign out_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    sh_valid  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = armed_q;
        if (acc) state_d = dec_skip ? DONE : SHIFT;
      end
      SHIFT: begin
        sh_valid = 1'b1;
        if (sh_ready) state_d = CHECK;
      end
      CHECK: begin
        if (msb_valid) state_d = (|need_d) ? FIX : DONE;
      end
      FIX: state_d = SHIFT;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      zero_q <= '0;
      err_q  <= 1'b0;
      fix_q  <= '0;
      need_q <= '0;
    end else begin
      if (acc) begin
        cont_q <= in_cont;
        hi_q   <= dec_hi;
        lo_q   <= dec_lo;
        zero_q <= dec_zero;
        err_q  <= 1'b0;
        fix_q  <= '0;
      end
      if (state_q == CHECK && msb_valid) need_q <= need_d;
      // at the limit the amount is held and the miss is reported
      if (state_q == FIX) begin
        fix_q <= fix_q + 2'd1;
        if (need_q[1]) begin
          if (hi_ovf) err_q <= 1'b1;
          else        hi_q  <= hi_inc[5:0];
        end
        if (need_q[0]) begin
          if (lo_ovf) err_q <= 1'b1;
          else        lo_q  <= lo_inc[4:0];
        end
      end
    end
  end

`ifdef MAF_NORM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_fix <= '0;
    end else begin
      if (out_valid && out_ready) stat_ops <= stat_ops + 16'd1;
      if (state_q == FIX)         stat_fix <= stat_fix + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_maf_norm_sched.sv
// Vector table + scoreboard bench for maf_norm_sched.
// Emulates the shifter and consumer; ends with a single summary line.
module tb_maf_norm_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_cont = '0;
  logic [1:0] in_v = '0;
  logic [9:0] in_p = '0;
  logic       sh_valid;
  logic       sh_ready = 1'b0;
  logic [5:0] sh_amt_hi;
  logic [4:0] sh_amt_lo;
  logic       msb_valid = 1'b0;
  logic [1:0] msb = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_amt_hi;
  logic [4:0] out_amt_lo;
  logic [1:0] out_zero;
  logic       out_err;
`ifdef MAF_NORM_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_fix;
`endif

  always #5 clk = ~clk;

  maf_norm_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cont    (in_cont),
    .in_v       (in_v),
    .in_p       (in_p),
    .sh_valid   (sh_valid),
    .sh_ready   (sh_ready),
    .sh_amt_hi  (sh_amt_hi),
    .sh_amt_lo  (sh_amt_lo),
    .msb_valid  (msb_valid),
    .msb        (msb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_amt_hi (out_amt_hi),
    .out_amt_lo (out_amt_lo),
    .out_zero   (out_zero),
    .out_err    (out_err)
`ifdef MAF_NORM_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_fix   (stat_fix)
`endif
  );

  typedef struct {
    logic [2:0] cont;
    logic [1:0] v;
    logic [9:0] p;
    logic [1:0] msb1;
    logic [1:0] msb2;
    logic [5:0] s1hi;
    logic [4:0] s1lo;
    logic [5:0] s2hi;
    logic [4:0] s2lo;
    int         shifts;
    logic [5:0] ohi;
    logic [4:0] olo;
    logic [1:0] ozero;
    logic       oerr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vt[12];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int   n;
    int   shifts;
    bit   done;
    vec_t e;
    string s;
    s = $sformatf("v%0d", idx);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({s, "_rdy"}, in_ready, 1);
    in_valid = 1'b1;
    in_cont  = t.cont;
    in_v     = t.v;
    in_p     = t.p;
    tick();
    in_valid = 1'b0;
    sb.push_back(t);
    if (t.shifts > 0) chk({s, "_lat"}, sh_valid, 1);
    else              chk({s, "_lat"}, out_valid, 1);
    shifts = 0;
    done   = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (sh_valid) begin
        if (shifts == 0) begin
          chk({s, "_s1hi"}, sh_amt_hi, t.s1hi);
          chk({s, "_s1lo"}, sh_amt_lo, t.s1lo);
        end else begin
          chk({s, "_s2hi"}, sh_amt_hi, t.s2hi);
          chk({s, "_s2lo"}, sh_amt_lo, t.s2lo);
        end
        shifts++;
        sh_ready = 1'b1;
        tick();
        sh_ready = 1'b0;
        msb_valid = 1'b1;
        msb = (shifts == 1) ? t.msb1 : t.msb2;
        tick();
        msb_valid = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk({s, "_sb_empty"}, 1, 0);
        end else begin
          e = sb.pop_front();
          chk({s, "_hi"}, out_amt_hi, e.ohi);
          chk({s, "_lo"}, out_amt_lo, e.olo);
          chk({s, "_zero"}, out_zero, e.ozero);
          chk({s, "_err"}, out_err, e.oerr);
          chk({s, "_nshift"}, shifts, e.shifts);
        end
        chk({s, "_busy"}, in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({s, "_rdy_after"}, in_ready, 1);
        done = 1;
      end else begin
        tick();
      end
    end
    if (!done) chk({s, "_timeout"}, 0, 1);
  endtask

  initial begin
    bit seen;
    // cont v p msb1 msb2 s1hi s1lo s2hi s2lo n ohi olo zero err
    vt[0]  = '{3'b000, 2'b10, 10'b00011_00000, 2'b10, 2'b00,
               3, 0, 0, 0, 1, 3, 0, 2'b00, 0};
    vt[1]  = '{3'b000, 2'b01, 10'd7, 2'b00, 2'b10,
               39, 0, 40, 0, 2, 40, 0, 2'b00, 0};
    vt[2]  = '{3'b001, 2'b11, 10'b00100_00010, 2'b01, 2'b11,
               4, 2, 5, 2, 2, 5, 2, 2'b00, 0};
    vt[3]  = '{3'b011, 2'b11, 10'h3FF, 2'b00, 2'b00,
               0, 0, 0, 0, 0, 0, 0, 2'b11, 0};
    vt[4]  = '{3'b001, 2'b11, {5'd27, 5'd3}, 2'b01, 2'b00,
               27, 3, 27, 3, 2, 27, 3, 2'b00, 1};
    vt[5]  = '{3'b010, 2'b00, 10'h155, 2'b00, 2'b00,
               0, 0, 0, 0, 0, 0, 0, 2'b10, 0};
    vt[6]  = '{3'b001, 2'b00, 10'b00101_00110, 2'b00, 2'b00,
               0, 0, 0, 0, 0, 5, 6, 2'b11, 0};
    vt[7]  = '{3'b010, 2'b11, {5'd31, 5'd4}, 2'b00, 2'b00,
               31, 0, 32, 0, 2, 32, 0, 2'b00, 0};
    vt[8]  = '{3'b000, 2'b01, 10'd23, 2'b00, 2'b10,
               55, 0, 55, 0, 2, 55, 0, 2'b00, 1};
    vt[9]  = '{3'b001, 2'b01, {5'd9, 5'd27}, 2'b00, 2'b00,
               9, 27, 9, 27, 2, 9, 27, 2'b10, 1};
    vt[10] = '{3'b001, 2'b11, {5'd26, 5'd26}, 2'b00, 2'b11,
               26, 26, 27, 27, 2, 27, 27, 2'b00, 0};
    vt[11] = '{3'b000, 2'b11, {5'd2, 5'd20}, 2'b10, 2'b00,
               2, 0, 0, 0, 1, 2, 0, 2'b00, 0};

    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sh_valid", sh_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_amt", {out_amt_hi, out_amt_lo}, 0);
    chk("rst_zero_err", {out_zero, out_err}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rel_ready_lo", in_ready, 0);
    tick();
    chk("rel_ready_hi", in_ready, 1);

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // abandon an operation while waiting on the MSB report
    in_valid = 1'b1;
    in_cont  = 3'b000;
    in_v     = 2'b01;
    in_p     = 10'd7;
    tick();
    in_valid = 1'b0;
    chk("mid_sh_valid", sh_valid, 1);
    sh_ready = 1'b1;
    tick();
    sh_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sh", sh_valid, 0);
    chk("mid_rst_out", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_amt", out_amt_hi, 0);
    tick();
    rst_n = 1'b1;
    chk("mid_rel_lo", in_ready, 0);
    tick();
    chk("mid_rel_hi", in_ready, 1);
    msb_valid = 1'b1;
    msb = 2'b00;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      msb_valid = 1'b0;
      if (out_valid || sh_valid) seen = 1;
    end
    chk("mid_no_output", seen, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
